// File: rtl/updi_frame_packer.sv
// updi_frame_packer
// Packs a byte/BREAK stream from the command generator into 12-bit UPDI UART
// frames (start, 8 data bits LSB-first, even parity, 2 stops). It writes them
// sequentially into the shared frame memory, pads the rest of the memory with
// idle frames, and pulses the loader's transmit enable. It then waits for the
// loader to report completion before it accepts the next message.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   s_valid/s_ready     item handshake; s_data byte, s_brk BREAK item,
//                       s_last marks the final item of a message
//   csb0, web0          memory chip select / write enable (active-low)
//   addr0, din0         memory word address / frame word
//   ten                 loader transmit enable (active-low, one-cycle pulse)
//   ld_done             loader finished (active-high pulse)
//   busy                high whenever the packer is not idle
//   trunc               one-cycle pulse on the write of a message cut at DEPTH
//   word_cnt            data/break words written in the current message
module updi_frame_packer #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 128,
    parameter logic [11:0] IDLE_WORD = 12'hFFF,
    parameter logic [11:0] BRK_WORD  = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_brk,
    input  logic              s_last,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [11:0]       din0,
    output logic              ten,
    input  logic              ld_done,
    output logic              busy,
    output logic              trunc,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PACK = 3'd1,
        ST_PAD  = 3'd2,
        ST_KICK = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // UART frame: bit 0 (start) goes out first, then data LSB-first,
    // even parity, and two stop bits.
    function automatic logic [11:0] make_frame(input logic [7:0] data);
        return {2'b11, ^data, data, 1'b0};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                csb0_q, csb0_d;
    logic                web0_q, web0_d;
    logic [ADDR_W-1:0]   addr0_q, addr0_d;
    logic [11:0]         din0_q, din0_d;
    logic                ten_q, ten_d;
    logic                s_ready_q, s_ready_d;
    logic                busy_q, busy_d;
    logic                trunc_q, trunc_d;
    logic                accept_s;

    // Next-state and next-output computation for the packing FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_cnt_d = word_cnt_q;
        csb0_d     = 1'b1;
        web0_d     = 1'b1;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
        ten_d      = 1'b1;
        trunc_d    = 1'b0;
        accept_s   = s_valid && s_ready_q;

        case (state_q)
            ST_IDLE, ST_PACK: begin
                if (accept_s) begin
                    csb0_d     = 1'b0;
                    web0_d     = 1'b0;
                    addr0_d    = ptr_q;
                    din0_d     = s_brk ? BRK_WORD : make_frame(s_data);
                    ptr_d      = ptr_q + 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    // Memory full: the item ends the message whatever s_last
                    // says, and nothing is left to pad.
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_KICK;
                        trunc_d = !s_last;
                    end else if (s_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_PACK;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAD: begin
                csb0_d  = 1'b0;
                web0_d  = 1'b0;
                addr0_d = ptr_q;
                din0_d  = IDLE_WORD;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_KICK;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_KICK: begin
                ten_d   = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ld_done) begin
                    state_d    = ST_IDLE;
                    ptr_d      = '0;
                    word_cnt_d = '0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered flags are derived from the state being entered so they
        // line up with state_q in the following cycle.
        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_PACK);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            word_cnt_q <= '0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            addr0_q    <= '0;
            din0_q     <= IDLE_WORD;
            ten_q      <= 1'b1;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_cnt_q <= word_cnt_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            ten_q      <= ten_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            trunc_q    <= trunc_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign csb0     = csb0_q;
    assign web0     = web0_q;
    assign addr0    = addr0_q;
    assign din0     = din0_q;
    assign ten      = ten_q;
    assign busy     = busy_q;
    assign trunc    = trunc_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: doc/updi_frame_packer.md
Name: updi_frame_packer

Overview:
Upstream neighbour of the UPDI physical-layer loader. It accepts a byte stream from the command generator and converts each byte into a 12-bit UPDI UART frame: start bit, 8 data bits LSB-first, even parity, and 2 stop bits. It can also insert a 12-bit BREAK, and writes the frames sequentially into the shared 12-bit frame memory. Once a message is complete it pads the remaining memory with idle frames, kicks the loader, and waits for the loader to finish before accepting the next message.

Parameters:
ADDR_W, 7, frame-memory word-address width.
DEPTH, 128, number of frame words (must equal 2**ADDR_W).
IDLE_WORD, 12'hFFF, pad frame (line held high).
BRK_WORD, 12'h000, BREAK frame (line held low for 12 bits).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  byte/break request valid.
s_ready  out  1  packer can accept this cycle.
s_data  in  8  byte to frame.
s_brk  in  1  with s_valid: write BREAK_WORD; s_data is ignored.
s_last  in  1  with s_valid: this is the final item of the message.
csb0  out  1  memory chip select, active-low.
web0  out  1  memory write enable, active-low.
addr0  out  ADDR_W  memory word address.
din0  out  12  frame word to memory.
ten  out  1  loader transmit enable, active-low, one-cycle pulse.
ld_done  in  1  loader finished transmission, active-high pulse.
busy  out  1  high in any state other than IDLE.
trunc  out  1  one-cycle pulse when a message is cut at DEPTH items.
word_cnt  out  ADDR_W+1  number of data/break words written in the current message.

Behaviour:
- Reset values (asynchronous, all outputs registered):
  - state=IDLE, csb0=1, web0=1, addr0=0, din0=IDLE_WORD, ten=1.
  - s_ready=0, busy=0, trunc=0, word_cnt=0.
- Frame layout, bit 0 sent first:
  - bit0 = 0 (start).
  - bits[8:1] = s_data[7:0].
  - bit9 = ^s_data (even parity).
  - bits[11:10] = 2'b11 (stops).
  - A BREAK item writes BRK_WORD with no parity.
- States: IDLE, PACK, PAD, KICK, WAIT.
- IDLE:
  - s_ready=1; addr pointer=0.
  - A handshake (s_valid&&s_ready) records the item and enters PACK.
- PACK:
  - s_ready=1.
  - An item accepted in cycle N appears on the memory port in cycle N+1: csb0=0, web0=0, addr0=pointer, din0=frame. The pointer and word_cnt then increment.
  - Without a handshake: csb0=1, web0=1, and the pointer holds.
- Message end:
  - Accepting an item with s_last=1 sets s_ready=0 from the next cycle and moves to PAD after that item's write.
  - If the item written to address DEPTH-1 has s_last=0, it is still treated as last: trunc pulses in the write cycle and the state goes directly to KICK.
- PAD:
  - One write per cycle of IDLE_WORD to addresses pointer..DEPTH-1.
  - If the last data write was at address DEPTH-1, PAD is skipped and the state goes to KICK.
  - word_cnt does not count pad writes.
- KICK:
  - csb0=1, web0=1, ten=0 for exactly one cycle, then WAIT.
- WAIT:
  - s_ready=0, memory idle.
  - ld_done=1 returns the state to IDLE, clears word_cnt and resets the pointer to 0.
  - An ld_done seen in any other state is ignored.
- Latency:
  - Single-item message (s_last in IDLE): handshake at cycle 0, write at cycle 1, pads at cycles 2..DEPTH, ten low at cycle DEPTH+1.
- Simultaneous events:
  - s_brk and s_last together give a break item that also ends the message.
  - s_valid while s_ready=0 is not consumed; the requester holds it.
- Reset during operation:
  - Returns immediately to the reset values.
  - Memory contents are undefined and no ten pulse is issued.
- The pointer never wraps inside one message; it is ADDR_W bits wide and reset to 0 on entry to IDLE.

Test Plan:
- Reset mid-PAD → all outputs at reset values the same cycle; the next message starts writing at addr0=0.
- Single byte 0x55 with s_last → write addr0=0, din0=12'hCAA; addresses 1..127 receive 12'hFFF; ten low for 1 cycle after the addr0=127 write; busy until ld_done.
- Sequence BREAK, 0x55, 0x01(last) → addr0 0/1/2 = 12'h000/12'hCAA/12'hE02; word_cnt=3; pads start at addr0=3.
- s_valid held for 130 bytes of 0x00 (last never set) → 128 writes of 12'hC00; trunc pulse at the addr0=127 write; no PAD state; ten pulses; bytes 129-130 wait until IDLE.
- s_valid toggling every other cycle → writes occur only on the cycle after each handshake, with addresses contiguous; ld_done pulsed during PACK is ignored and the state is unchanged.
